// File: rtl/toggle_monitor.sv
// ============================================================================
// Module      : toggle_monitor
// Description : Edge detector, saturating toggle counter, run-length meter
//               and stall flag for a T flip-flop output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_monitor #(
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             q_in,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             overflow,
    output logic [CNT_W-1:0] run_len,
    output logic             run_level,
    output logic             run_valid,
    output logic             stall
);

    localparam logic [CNT_W-1:0] c_cnt_max     = '1;
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_stall_limit = CNT_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_q_d;
    logic [CNT_W-1:0] r_run_cnt;
    logic             r_edge_rise;
    logic             r_edge_fall;
    logic [CNT_W-1:0] r_toggle_cnt;
    logic             r_overflow;
    logic [CNT_W-1:0] r_run_len;
    logic             r_run_level;
    logic             r_run_valid;
    logic             r_stall;

    logic [CNT_W-1:0] w_run_inc;
    logic             w_edge;

    assign w_run_inc = (r_run_cnt == c_cnt_max) ? r_run_cnt : r_run_cnt + c_cnt_one;
    assign w_edge    = (q_in != r_q_d);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state      <= IDLE;
            r_q_d        <= 1'b0;
            r_run_cnt    <= '0;
            r_edge_rise  <= 1'b0;
            r_edge_fall  <= 1'b0;
            r_toggle_cnt <= '0;
            r_overflow   <= 1'b0;
            r_run_len    <= '0;
            r_run_level  <= 1'b0;
            r_run_valid  <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_edge_rise <= 1'b0;
            r_edge_fall <= 1'b0;
            r_run_valid <= 1'b0;
            if (en) begin
                case (r_state)
                    // Prime on the first enabled sample so no false edge follows reset
                    IDLE: begin
                        r_q_d     <= q_in;
                        r_run_cnt <= c_cnt_one;
                        r_state   <= TRACK;
                    end
                    default: begin
                        if (w_edge) begin
                            r_edge_rise <= q_in;
                            r_edge_fall <= ~q_in;
                            r_run_valid <= 1'b1;
                            r_run_len   <= r_run_cnt;
                            r_run_level <= r_q_d;
                            r_q_d       <= q_in;
                            r_run_cnt   <= c_cnt_one;
                            if (r_toggle_cnt == c_cnt_max) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_toggle_cnt <= r_toggle_cnt + c_cnt_one;
                            end
                            r_state <= TRACK;
                            r_stall <= 1'b0;
                        end else begin
                            r_run_cnt <= w_run_inc;
                            if (w_run_inc >= c_stall_limit) begin
                                r_state <= STALL;
                                r_stall <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign edge_rise  = r_edge_rise;
    assign edge_fall  = r_edge_fall;
    assign toggle_cnt = r_toggle_cnt;
    assign overflow   = r_overflow;
    assign run_len    = r_run_len;
    assign run_level  = r_run_level;
    assign run_valid  = r_run_valid;
    assign stall      = r_stall;

endmodule

`default_nettype wire

// File: doc/toggle_monitor.md
# toggle_monitor

Downstream observer for the T flip-flop output. Samples the flip-flop's `q` every enabled cycle and detects rising and falling edges. Counts toggles, measures how many cycles each level lasted, and flags a stalled output that has not toggled within a programmable limit. It sits directly after the T flip-flop and feeds status and debug logic.

## Interface
- `CNT_W`, default 8: width of the toggle counter and the run-length counter.
- `STALL_LIMIT`, default 16: number of consecutive equal samples that raises `stall`. Legal range is 2 to 2^CNT_W-1.

Ports:
- `clk`, in, 1: single clock. All logic updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: sample enable. When low, all state is frozen.
- `clr`, in, 1: synchronous clear of the counters and flags.
- `q_in`, in, 1: the T flip-flop `q` output.
- `edge_rise`, out, 1: one-cycle pulse when a 0→1 edge is detected.
- `edge_fall`, out, 1: one-cycle pulse when a 1→0 edge is detected.
- `toggle_cnt`, out, CNT_W: saturating count of detected edges.
- `overflow`, out, 1: sticky flag, set when an edge arrives while `toggle_cnt` is at its maximum.
- `run_len`, out, CNT_W: length in cycles of the level that just ended. Valid with `run_valid`.
- `run_level`, out, 1: the value of the level that just ended.
- `run_valid`, out, 1: one-cycle pulse, coincident with `edge_rise`/`edge_fall`.
- `stall`, out, 1: level signal. High while `q_in` has not toggled for at least `STALL_LIMIT` samples.

## Operation
Internal state:
- `q_d`: last sampled level.
- `run_cnt`: CNT_W bits, saturates at 2^CNT_W-1.
- FSM with states `IDLE`, `TRACK`, `STALL`.

Reset, on `rst`=1:
- All outputs 0, `q_d`=0, `run_cnt`=0, state `IDLE`.
- `rst` overrides `en` and `clr`.

Clear, on `clr`=1 with `rst`=0:
- Same effect as reset, and it acts regardless of `en`.
- `clr` wins over a simultaneous edge; no pulse is emitted.

When `en`=0, nothing changes and the pulse outputs are 0.

IDLE, on the first cycle with `en`=1:
- `q_d` ← `q_in`, `run_cnt` ← 1, go to `TRACK`.
- No edge is reported, so no false edge follows reset.

TRACK or STALL, each cycle with `en`=1:
- Edge (`q_in` ≠ `q_d`):
  - Assert `edge_rise` (if `q_in`=1) or `edge_fall`, plus `run_valid`.
  - `run_len` ← `run_cnt`, `run_level` ← `q_d`.
  - `q_d` ← `q_in`, `run_cnt` ← 1.
  - `toggle_cnt` +1 if below max; otherwise hold it and set `overflow`.
  - Go to `TRACK` and clear `stall`.
- No edge:
  - `run_cnt` +1, saturating.
  - If the new `run_cnt` ≥ `STALL_LIMIT`, go to / stay in `STALL` with `stall`=1.

Output behaviour:
- `run_len` and `run_level` hold their last value between pulses.
- `toggle_cnt` never wraps.
- A run longer than 2^CNT_W-1 reports `run_len` = 2^CNT_W-1.

## Timing
- All outputs are registered.
- An edge on `q_in` sampled at rising edge k gives pulses high during cycle k→k+1, for exactly one cycle.
- `toggle_cnt` shows the updated value in the same cycle as the pulse.
- `stall` rises in the cycle after the sample at which `run_cnt` reaches `STALL_LIMIT`.
- `stall` falls together with the pulse of the next edge.
- Back-to-back edges on every cycle are supported: each cycle produces a pulse with `run_len`=1.
- A reset or clear mid-run discards the partial run. The first `en` cycle afterwards re-primes in `IDLE`, so the first edge cannot appear before the second enabled cycle.

## Test plan
- **Reset with high input.** `rst` for 2 cycles, then `en`=1 with `q_in`=1 held.
  - Required: no `edge_rise` ever; `toggle_cnt`=0.
- **Toggle every cycle.** T flip-flop upstream with `t`=1 continuously, `en`=1, 10 cycles after prime.
  - Required: pulses alternate rise/fall every cycle; every `run_len`=1; `toggle_cnt`=10.
- **Known run lengths.** `q_in` pattern 0 for 3 samples, 1 for 5, 0 for 2.
  - Required: `run_valid` with `run_len`=3 / `run_level`=0, then `run_len`=5 / `run_level`=1.
  - Required: `toggle_cnt`=2.
- **Stall.** Hold `q_in`=0 after prime, `STALL_LIMIT`=16.
  - Required: `stall` rises after the 16th equal sample.
  - Then toggle `q_in`: `stall` drops with `edge_rise`; `run_len`=16 + extra held cycles, saturating at 255.
- **Saturation.** `CNT_W`=4 with 17 edges.
  - Required: `toggle_cnt`=15; `overflow`=1 from the 16th edge.
  - Then `clr`: all zero, state `IDLE`.
- **Priority and freeze.**
  - `clr` in the same cycle as an edge → no pulse, counters 0.
  - `en`=0 while `q_in` toggles → no pulses, counters unchanged.
  - `rst` asserted mid-`STALL` → `stall`=0 on the next cycle.
